// File: rtl/ex_hazard_ctrl_if.sv
// Bundle between the pipeline datapath and the EX hazard/forwarding controller.
// master = pipeline side (drives ID decode, stall and redirect causes); slave = controller.
interface ex_hazard_ctrl_if #(
  parameter int CNT_W = 32
);
  logic             id_valid;
  logic [4:0]       id_rs1;
  logic [4:0]       id_rs2;
  logic             id_use_rs1;
  logic             id_use_rs2;
  logic [4:0]       id_rd;
  logic             id_regwrite;
  logic             id_is_load;
  logic             dmem_stall;
  logic             br_flush;

  logic [1:0]       forwardA;
  logic [1:0]       forwardB;
  logic             stall_pc;
  logic             stall_if_id;
  logic             bubble_ex;
  logic             freeze;
  logic             flush_if_id;
  logic [CNT_W-1:0] lu_stall_cnt;
  logic [CNT_W-1:0] freeze_cnt;
  logic [CNT_W-1:0] flush_cnt;

  // Debug view: current priority mode and the packed {ex, mem, wb} shadow slots.
  logic [1:0]       mode;
  logic [23:0]      slots;

  modport master (
    output id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_rd,
           id_regwrite, id_is_load, dmem_stall, br_flush,
    input  forwardA, forwardB, stall_pc, stall_if_id, bubble_ex, freeze,
           flush_if_id, lu_stall_cnt, freeze_cnt, flush_cnt, mode, slots
  );

  modport slave (
    input  id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_rd,
           id_regwrite, id_is_load, dmem_stall, br_flush,
    output forwardA, forwardB, stall_pc, stall_if_id, bubble_ex, freeze,
           flush_if_id, lu_stall_cnt, freeze_cnt, flush_cnt, mode, slots
  );
endinterface

// File: rtl/ex_hazard_ctrl.sv
// EX-stage hazard controller: shadows rd state of EX/MEM/WB, registers forwarding selects
// one cycle ahead, inserts load-use bubbles, sequences freezes and redirect kills.
module ex_hazard_ctrl #(
  parameter int CNT_W = 32
) (
  input logic            clk,
  input logic            rst,
  ex_hazard_ctrl_if.slave hz
);

  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    logic       regwrite;
    logic       is_load;
  } slot_t;

  typedef enum logic [1:0] {
    M_RUN    = 2'd0,
    M_FREEZE = 2'd1,
    M_FLUSH  = 2'd2,
    M_LU     = 2'd3
  } mode_t;

  slot_t            ex_s, mem_s, wb_s;
  slot_t            ex_next;
  mode_t            mode;
  logic             lu;
  logic [1:0]       fwd_a_next, fwd_b_next;
  logic [1:0]       fwd_a_q, fwd_b_q;
  logic [CNT_W-1:0] lu_cnt_q, freeze_cnt_q, flush_cnt_q;

  function automatic logic writing(input slot_t s);
    return s.valid & s.regwrite & (s.rd != 5'd0);
  endfunction

  // ex_s feeds MEM next cycle (01), mem_s feeds WB next cycle (10); MEM wins.
  function automatic logic [1:0] fwd_sel(input logic use_rs, input logic [4:0] rs,
                                         input slot_t ex, input slot_t mem);
    if (!use_rs || rs == 5'd0) return 2'b00;
    if (writing(ex) && ex.rd == rs) return 2'b01;
    if (writing(mem) && mem.rd == rs) return 2'b10;
    return 2'b00;
  endfunction

  always_comb begin
    lu = hz.id_valid & writing(ex_s) & ex_s.is_load &
         ((hz.id_use_rs1 & (hz.id_rs1 == ex_s.rd)) |
          (hz.id_use_rs2 & (hz.id_rs2 == ex_s.rd)));
  end

  always_comb begin
    mode = M_RUN;
    if (hz.dmem_stall)    mode = M_FREEZE;
    else if (hz.br_flush) mode = M_FLUSH;
    else if (lu)          mode = M_LU;
  end

  always_comb begin
    hz.freeze      = 1'b0;
    hz.stall_pc    = 1'b0;
    hz.stall_if_id = 1'b0;
    hz.bubble_ex   = 1'b0;
    hz.flush_if_id = 1'b0;
    ex_next        = '{valid: hz.id_valid, rd: hz.id_rd,
                       regwrite: hz.id_regwrite, is_load: hz.id_is_load};
    case (mode)
      M_FREEZE: begin
        hz.freeze      = 1'b1;
        hz.stall_pc    = 1'b1;
        hz.stall_if_id = 1'b1;
      end
      M_FLUSH: begin
        hz.flush_if_id = 1'b1;
        hz.bubble_ex   = 1'b1;
        ex_next        = '0;
      end
      M_LU: begin
        hz.stall_pc    = 1'b1;
        hz.stall_if_id = 1'b1;
        hz.bubble_ex   = 1'b1;
        ex_next        = '0;
      end
      default: ;
    endcase
  end

  always_comb begin
    fwd_a_next = fwd_sel(hz.id_use_rs1, hz.id_rs1, ex_s, mem_s);
    fwd_b_next = fwd_sel(hz.id_use_rs2, hz.id_rs2, ex_s, mem_s);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ex_s  <= '0;
      mem_s <= '0;
      wb_s  <= '0;
    end else if (mode != M_FREEZE) begin
      ex_s  <= ex_next;
      mem_s <= ex_s;
      wb_s  <= mem_s;
    end
  end

  // A bubble or a flush enters EX as a NOP, so it must not carry a forward select.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fwd_a_q <= 2'b00;
      fwd_b_q <= 2'b00;
    end else if (mode != M_FREEZE) begin
      fwd_a_q <= hz.bubble_ex ? 2'b00 : fwd_a_next;
      fwd_b_q <= hz.bubble_ex ? 2'b00 : fwd_b_next;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lu_cnt_q     <= '0;
      freeze_cnt_q <= '0;
      flush_cnt_q  <= '0;
    end else begin
      if (mode == M_LU && lu_cnt_q != '1)         lu_cnt_q     <= lu_cnt_q + 1'b1;
      if (mode == M_FREEZE && freeze_cnt_q != '1) freeze_cnt_q <= freeze_cnt_q + 1'b1;
      if (mode == M_FLUSH && flush_cnt_q != '1)   flush_cnt_q  <= flush_cnt_q + 1'b1;
    end
  end

  assign hz.forwardA     = fwd_a_q;
  assign hz.forwardB     = fwd_b_q;
  assign hz.lu_stall_cnt = lu_cnt_q;
  assign hz.freeze_cnt   = freeze_cnt_q;
  assign hz.flush_cnt    = flush_cnt_q;
  assign hz.mode         = mode;
  assign hz.slots        = {ex_s, mem_s, wb_s};

endmodule

// File: tb/tb_ex_hazard_ctrl.sv
// Directed scoreboard bench for ex_hazard_ctrl: forwarding, load-use, x0/unused operands,
// flush-vs-load-use priority, freeze hold, counter saturation and asynchronous reset.
module tb_ex_hazard_ctrl;
  localparam int CNT_W = 2;

  // Control vector order: {freeze, stall_pc, stall_if_id, bubble_ex, flush_if_id}
  localparam logic [4:0] C_NONE  = 5'b00000;
  localparam logic [4:0] C_LU    = 5'b01110;
  localparam logic [4:0] C_FRZ   = 5'b11100;
  localparam logic [4:0] C_FLUSH = 5'b00011;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_bad;

  logic [4:0] ctrl_q[$];
  logic [3:0] fwd_q[$];

  ex_hazard_ctrl_if #(.CNT_W(CNT_W)) hz ();

  ex_hazard_ctrl #(.CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .hz  (hz)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [4:0] ctrl_obs();
    return {hz.freeze, hz.stall_pc, hz.stall_if_id, hz.bubble_ex, hz.flush_if_id};
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // One instruction presented in ID for one cycle: controls are checked in-cycle,
  // the registered forward selects after the edge.
  task automatic instr(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic u1, input logic u2, input logic rw, input logic ld,
                       input logic dm, input logic br, input logic [4:0] e_ctrl,
                       input logic [1:0] e_a, input logic [1:0] e_b, input string tag);
    @(negedge clk);
    hz.id_valid    = 1'b1;
    hz.id_rd       = rd;
    hz.id_rs1      = rs1;
    hz.id_rs2      = rs2;
    hz.id_use_rs1  = u1;
    hz.id_use_rs2  = u2;
    hz.id_regwrite = rw;
    hz.id_is_load  = ld;
    hz.dmem_stall  = dm;
    hz.br_flush    = br;
    ctrl_q.push_back(e_ctrl);
    fwd_q.push_back({e_a, e_b});
    #1;
    check_eq({tag, "_ctrl"}, 32'(ctrl_obs()), 32'(ctrl_q.pop_front()));
    @(posedge clk);
    #1;
    check_eq({tag, "_fwd"}, 32'({hz.forwardA, hz.forwardB}), 32'(fwd_q.pop_front()));
  endtask

  task automatic idle_inputs();
    hz.id_valid    = 1'b0;
    hz.id_rd       = 5'd0;
    hz.id_rs1      = 5'd0;
    hz.id_rs2      = 5'd0;
    hz.id_use_rs1  = 1'b0;
    hz.id_use_rs2  = 1'b0;
    hz.id_regwrite = 1'b0;
    hz.id_is_load  = 1'b0;
    hz.dmem_stall  = 1'b0;
    hz.br_flush    = 1'b0;
  endtask

  task automatic check_cnts(input string tag, input int lu_e, input int frz_e, input int fl_e);
    check_eq({tag, "_lu_cnt"},     32'(hz.lu_stall_cnt), 32'(lu_e));
    check_eq({tag, "_freeze_cnt"}, 32'(hz.freeze_cnt),   32'(frz_e));
    check_eq({tag, "_flush_cnt"},  32'(hz.flush_cnt),    32'(fl_e));
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    idle_inputs();
    rst = 1'b0;

    // reset state; freeze follows dmem_stall even in reset
    #12;
    check_eq("rst_ctrl", 32'(ctrl_obs()), 32'(C_NONE));
    check_eq("rst_fwd", 32'({hz.forwardA, hz.forwardB}), 32'd0);
    check_cnts("rst", 0, 0, 0);
    hz.dmem_stall = 1'b1;
    #1;
    check_eq("rst_dmem_ctrl", 32'(ctrl_obs()), 32'(C_FRZ));
    hz.dmem_stall = 1'b0;
    @(negedge clk);
    rst = 1'b1;

    // back-to-back ALU dependency
    instr(5'd5,  5'd1, 5'd2, 1, 1, 1, 0, 0, 0, C_NONE, 2'b00, 2'b00, "add_x5");
    instr(5'd6,  5'd5, 5'd7, 1, 1, 1, 0, 0, 0, C_NONE, 2'b01, 2'b00, "sub_dep");
    // distance-2 with MEM priority over WB, then WB-distance reader
    instr(5'd5,  5'd1, 5'd2, 1, 1, 1, 0, 0, 0, C_NONE, 2'b00, 2'b00, "add_x5a");
    instr(5'd5,  5'd1, 5'd2, 1, 1, 1, 0, 0, 0, C_NONE, 2'b00, 2'b00, "add_x5b");
    instr(5'd8,  5'd5, 5'd5, 1, 1, 1, 0, 0, 0, C_NONE, 2'b01, 2'b01, "or_prio");
    instr(5'd10, 5'd5, 5'd0, 1, 1, 1, 0, 0, 0, C_NONE, 2'b10, 2'b00, "rd_wb");

    // load-use: one bubble, retried consumer gets WB forward
    instr(5'd3,  5'd1, 5'd0, 1, 0, 1, 1, 0, 0, C_NONE, 2'b00, 2'b00, "lw_x3");
    instr(5'd4,  5'd3, 5'd1, 1, 1, 1, 0, 0, 0, C_LU,   2'b00, 2'b00, "lu_stall");
    instr(5'd4,  5'd3, 5'd1, 1, 1, 1, 0, 0, 0, C_NONE, 2'b10, 2'b00, "lu_retry");
    check_cnts("after_lu", 1, 0, 0);

    // x0 destination and unused operands never stall or forward
    instr(5'd0,  5'd1, 5'd0, 1, 0, 1, 1, 0, 0, C_NONE, 2'b00, 2'b00, "lw_x0");
    instr(5'd1,  5'd0, 5'd0, 1, 1, 1, 0, 0, 0, C_NONE, 2'b00, 2'b00, "add_x0src");
    instr(5'd2,  5'd6, 5'd0, 1, 0, 1, 1, 0, 0, C_NONE, 2'b00, 2'b00, "lw_x2");
    instr(5'd2,  5'd2, 5'd2, 0, 0, 1, 0, 0, 0, C_NONE, 2'b00, 2'b00, "lui_x2");

    // flush beats a simultaneous load-use
    instr(5'd7,  5'd6, 5'd0, 1, 0, 1, 1, 0, 0, C_NONE, 2'b00, 2'b00, "lw_x7");
    instr(5'd8,  5'd7, 5'd7, 1, 1, 1, 0, 0, 1, C_FLUSH, 2'b00, 2'b00, "flush_lu");
    check_cnts("after_flush", 1, 0, 1);
    instr(5'd11, 5'd7, 5'd2, 1, 1, 1, 0, 0, 0, C_NONE, 2'b10, 2'b00, "post_flush");

    // freeze for 3 cycles over a pending load-use; flush ignored while frozen
    instr(5'd13, 5'd11, 5'd0, 1, 0, 1, 1, 0, 0, C_NONE, 2'b01, 2'b00, "lw_x13");
    instr(5'd14, 5'd13, 5'd0, 1, 1, 1, 0, 1, 1, C_FRZ,  2'b01, 2'b00, "frz1");
    instr(5'd14, 5'd13, 5'd0, 1, 1, 1, 0, 1, 0, C_FRZ,  2'b01, 2'b00, "frz2");
    instr(5'd14, 5'd13, 5'd0, 1, 1, 1, 0, 1, 0, C_FRZ,  2'b01, 2'b00, "frz3");
    check_cnts("after_frz", 1, 3, 1);
    instr(5'd14, 5'd13, 5'd0, 1, 1, 1, 0, 0, 0, C_LU,   2'b00, 2'b00, "frz_lu");
    instr(5'd14, 5'd13, 5'd0, 1, 1, 1, 0, 0, 0, C_NONE, 2'b10, 2'b00, "frz_retry");
    check_cnts("after_frz_lu", 2, 3, 1);

    // one more freeze cycle: 2-bit freeze counter must stay saturated at 3
    instr(5'd15, 5'd14, 5'd0, 1, 0, 1, 1, 1, 0, C_FRZ,  2'b10, 2'b00, "frz_sat");
    check_eq("sat_freeze_cnt", 32'(hz.freeze_cnt), 32'd3);

    // async reset while a load-use bubble is asserted
    instr(5'd15, 5'd14, 5'd0, 1, 0, 1, 1, 0, 0, C_NONE, 2'b01, 2'b00, "lw_x15");
    @(negedge clk);
    hz.id_rd = 5'd16; hz.id_rs1 = 5'd15; hz.id_rs2 = 5'd1;
    hz.id_use_rs1 = 1'b1; hz.id_use_rs2 = 1'b1; hz.id_regwrite = 1'b1; hz.id_is_load = 1'b0;
    #1;
    check_eq("pre_rst_ctrl", 32'(ctrl_obs()), 32'(C_LU));
    check_eq("pre_rst_fwd", 32'({hz.forwardA, hz.forwardB}), 32'(4'b0100));
    rst = 1'b0;
    #1;
    check_eq("async_rst_ctrl", 32'(ctrl_obs()), 32'(C_NONE));
    check_eq("async_rst_fwd", 32'({hz.forwardA, hz.forwardB}), 32'd0);
    check_cnts("async_rst", 0, 0, 0);
    @(negedge clk);
    rst = 1'b1;
    instr(5'd16, 5'd15, 5'd1, 1, 1, 1, 0, 0, 0, C_NONE, 2'b00, 2'b00, "post_rst");
    check_cnts("post_rst", 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/ex_hazard_ctrl.md
# ex_hazard_ctrl

Hazard and forwarding controller for the five-stage RV32I pipeline. It keeps a shadow copy of the destination-register state of the EX, MEM and WB stages and computes the EX-stage forwarding selects (forwardA/forwardB) one cycle ahead, registering them as each instruction enters EX. It also detects load-use hazards and inserts a one-cycle bubble into ID/EX. It sequences freezes on data-memory stalls and kills on branch/jump redirects, and counts stall events for performance analysis.

## Interface
Parameters:
- CNT_W, 32, width of the stall/flush performance counters (saturating).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset; 0 forces the reset state immediately.
- id_valid  in  1  ID holds a real instruction.
- id_rs1, id_rs2  in  5  source registers of the ID instruction.
- id_use_rs1, id_use_rs2  in  1  the ID instruction actually reads rs1/rs2.
- id_rd  in  5  destination of the ID instruction.
- id_regwrite  in  1  the ID instruction writes rd.
- id_is_load  in  1  the ID instruction is a load.
- dmem_stall  in  1  MEM is waiting on data memory; the whole pipeline must hold.
- br_flush  in  1  EX resolved a taken branch/jump; kill the ID and IF instructions.
- forwardA, forwardB  out  2  EX forwarding selects, registered: 2'b00 rs_out, 2'b01 regfilemux_out_mem, 2'b10 regfilemux_out_wb; 2'b11 never driven.
- stall_pc, stall_if_id  out  1  hold PC and the IF/ID register.
- bubble_ex  out  1  load NOP (all control zero) into ID/EX instead of the ID instruction.
- freeze  out  1  all pipeline registers hold, including ID/EX, EX/MEM and MEM/WB.
- flush_if_id  out  1  load NOP into IF/ID.
- lu_stall_cnt, freeze_cnt, flush_cnt  out  CNT_W  performance counters.

## Operation
- Shadow slots ex_s, mem_s, wb_s, each holding {valid, rd, regwrite, is_load}. A slot is "writing" when valid & regwrite & rd != 0.
- Hazard (comb): lu = id_valid & ex_s writing & ex_s.is_load & ((id_use_rs1 & id_rs1 == ex_s.rd) | (id_use_rs2 & id_rs2 == ex_s.rd)).
- Priority, highest first:
  - dmem_stall: freeze = stall_pc = stall_if_id = 1; bubble_ex = flush_if_id = 0. br_flush is ignored; EX keeps asserting it until the freeze ends. No state changes except freeze_cnt +1.
  - br_flush: flush_if_id = bubble_ex = 1; no stall. ex_s <= invalid. flush_cnt +1. A simultaneous lu is discarded and lu_stall_cnt is not incremented.
  - lu: stall_pc = stall_if_id = bubble_ex = 1. ex_s <= invalid. lu_stall_cnt +1.
  - otherwise: all outputs 0 and ex_s <= {id_valid, id_rd, id_regwrite, id_is_load}.
- When not frozen, mem_s <= ex_s and wb_s <= mem_s every cycle.
- Forward select for the instruction entering EX, per operand (rs1 -> forwardA, rs2 -> forwardB):
  - 01 if ex_s is writing and ex_s.rd == rs (the producer will be in MEM next cycle);
  - else 10 if mem_s is writing and mem_s.rd == rs (the producer will be in WB);
  - else 00.
  - MEM takes priority over WB when both match. Register x0 never forwards. An operand that is unused gets 00.
- forwardA/B register update:
  - not frozen: register the computed value, or 00 when bubble_ex (bubble or flush);
  - frozen: hold.
- After a load-use bubble the load sits in mem_s, so the retried consumer receives 10 (WB forward). The register file provides write-before-read for producers that have already left WB; that is out of scope here.
- Counters saturate at all-ones and do not wrap.

## Timing
- Reset (rst = 0, asynchronous): all slots invalid, forwardA = forwardB = 00, all counters 0. With the slots invalid, stall_pc/stall_if_id/bubble_ex/flush_if_id are 0 unless dmem_stall = 1 (freeze stays a pure function of dmem_stall).
- stall_pc, stall_if_id, bubble_ex, freeze and flush_if_id are combinational in the same cycle as their cause. Pipeline registers act on them at the next edge.
- forwardA/B are valid for the entire cycle an instruction occupies EX: one register stage, computed in the preceding ID cycle.
- A load-use stall lasts exactly 1 cycle per load, because ex_s becomes invalid after the bubble.
- A freeze lasts exactly as long as dmem_stall is high. A load-use hazard pending under freeze is resolved on the first unfrozen cycle.
- Deassertion of rst is sampled cleanly; the first edge after release behaves as RUN with empty slots.

## Test plan
- Back-to-back ALU dependency: add x5 (cycle n), then sub x6,x5,x7 -> sub in EX has forwardA = 01, forwardB = 00; no stall.
- Distance-2 dependency with MEM/WB priority: add x5; add x5; or x8,x5,x5 -> forwardA = forwardB = 01. Then after one independent instruction, a reader of x5 gets 10.
- Load-use: lw x3 then add x4,x3,x1 -> one cycle of stall_pc = stall_if_id = bubble_ex = 1; add enters EX with forwardA = 10; lu_stall_cnt = 1.
- x0 and unused operands: lw x0 then add x1,x0,x0, and lw x2 then lui x2 -> no stall, forwards 00.
- Simultaneous br_flush + lu, then dmem_stall held 3 cycles during a dependency -> flush wins, lu_stall_cnt unchanged, flush_cnt = 1. During the freeze, forwardA/B and all slots hold, freeze_cnt = 3.
- Async reset mid-stall: assert rst = 0 while bubble_ex = 1 -> forwards 00, counters 0 and stall outputs 0 immediately, without waiting for a clock edge.
